// File: rtl/vpu_dst_port_pkg.sv
// Shared definitions for the VPU destination (result-to-SRAM) port.
// The write-request struct is also what the SRAM write interface consumes.
package vpu_dst_port_pkg;

    localparam int VPU_SRAM_DATA_WIDTH      = 256;
    localparam int VPU_EXEC_UNIT_DATA_WIDTH = 128;
    localparam int VPU_ADDR_W               = 10;
    localparam int VPU_LEN_W                = 4;
    localparam int DST_BEATS                = VPU_SRAM_DATA_WIDTH / VPU_EXEC_UNIT_DATA_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        DONE    = 2'd3
    } vpu_dst_state_t;

    typedef struct packed {
        logic                           wren;
        logic [VPU_ADDR_W-1:0]          waddr;
        logic [VPU_SRAM_DATA_WIDTH-1:0] wdata;
    } vpu_sram_wreq_t;

endpackage

// File: rtl/vpu_dst_port_packer.sv
// Packs BEATS result beats into one SRAM word, beat 0 in the LSBs.
// The beat counter wraps to zero on the last beat, so a full word leaves it ready for the next.
module vpu_dst_port_packer
    import vpu_dst_port_pkg::*;
#(
    parameter int EXEC_UNIT_DATA_WIDTH = VPU_EXEC_UNIT_DATA_WIDTH,
    parameter int BEATS                = DST_BEATS
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  clr_i,
    input  logic                                  push_i,
    input  logic [EXEC_UNIT_DATA_WIDTH-1:0]       data_i,
    output logic [BEATS*EXEC_UNIT_DATA_WIDTH-1:0] full_word_o,
    output logic                                  last_beat_o
);

    localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;

    logic [CW-1:0]                         cnt_q, cnt_d;
    logic [BEATS*EXEC_UNIT_DATA_WIDTH-1:0] pack_q, pack_d;

    assign last_beat_o = (cnt_q == CW'(BEATS - 1));
    assign full_word_o = pack_q;

    always_comb begin
        cnt_d  = cnt_q;
        pack_d = pack_q;
        if (clr_i) begin
            cnt_d  = '0;
            pack_d = '0;
        end else if (push_i) begin
            pack_d[cnt_q*EXEC_UNIT_DATA_WIDTH +: EXEC_UNIT_DATA_WIDTH] = data_i;
            cnt_d = last_beat_o ? '0 : cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
        end
    end

endmodule

// File: rtl/vpu_dst_port.sv
// VPU destination port: collects result beats into SRAM words and writes them
// to consecutive addresses, then pulses done to the controller.
//
//   state   | meaning
//   IDLE    | waiting for start_i; latches address and word count
//   COLLECT | accepting result beats into the pack buffer
//   WRITE   | holding a packed word on the SRAM write port until wready
//   DONE    | one-cycle completion pulse
module vpu_dst_port
    import vpu_dst_port_pkg::*;
#(
    parameter int SRAM_DATA_WIDTH      = VPU_SRAM_DATA_WIDTH,
    parameter int EXEC_UNIT_DATA_WIDTH = VPU_EXEC_UNIT_DATA_WIDTH,
    parameter int ADDR_W               = VPU_ADDR_W,
    parameter int LEN_W                = VPU_LEN_W
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start_i,
    input  logic                            wvalid_i,
    input  logic [ADDR_W-1:0]               waddr_i,
    input  logic [LEN_W-1:0]                len_i,
    input  logic                            result_valid_i,
    input  logic [EXEC_UNIT_DATA_WIDTH-1:0] result_data_i,
    output logic                            result_ready_o,
    output logic                            sram_wren_o,
    output logic [ADDR_W-1:0]               sram_waddr_o,
    output logic [SRAM_DATA_WIDTH-1:0]      sram_wdata_o,
    input  logic                            sram_wready_i,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int BEATS = SRAM_DATA_WIDTH / EXEC_UNIT_DATA_WIDTH;

    vpu_dst_state_t state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic [LEN_W:0]    wcnt_inc;

    logic                       pk_clr, pk_push, pk_last;
    logic [SRAM_DATA_WIDTH-1:0] pk_word;
    vpu_sram_wreq_t             wreq;

    vpu_dst_port_packer #(
        .EXEC_UNIT_DATA_WIDTH (EXEC_UNIT_DATA_WIDTH),
        .BEATS                (BEATS)
    ) u_packer (
        .clk         (clk),
        .rst_n       (rst_n),
        .clr_i       (pk_clr),
        .push_i      (pk_push),
        .data_i      (result_data_i),
        .full_word_o (pk_word),
        .last_beat_o (pk_last)
    );

    // Compare in one extra bit so len = 2^LEN_W - 1 terminates cleanly.
    assign wcnt_inc = {1'b0, wcnt_q} + (LEN_W+1)'(1);

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        len_d   = len_q;
        wcnt_d  = wcnt_q;
        pk_clr  = 1'b0;
        pk_push = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    addr_d  = waddr_i;
                    len_d   = len_i;
                    wcnt_d  = '0;
                    pk_clr  = 1'b1;
                    state_d = (!wvalid_i || len_i == '0) ? DONE : COLLECT;
                end
            end
            COLLECT: begin
                pk_push = result_valid_i;
                if (result_valid_i && pk_last) state_d = WRITE;
            end
            WRITE: begin
                if (sram_wready_i) begin
                    addr_d  = addr_q + ADDR_W'(1);
                    wcnt_d  = wcnt_inc[LEN_W-1:0];
                    state_d = (wcnt_inc == {1'b0, len_q}) ? DONE : COLLECT;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
        end
    end

    // Write port is zeroed outside WRITE so nothing stale leaks onto the bus.
    always_comb begin
        wreq       = '0;
        wreq.wren  = (state_q == WRITE);
        if (wreq.wren) begin
            wreq.waddr = addr_q;
            wreq.wdata = pk_word;
        end
    end

    assign sram_wren_o    = wreq.wren;
    assign sram_waddr_o   = wreq.waddr;
    assign sram_wdata_o   = wreq.wdata;
    assign result_ready_o = (state_q == COLLECT);
    assign busy_o         = (state_q != IDLE);
    assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_vpu_dst_port.sv
// Self-checking bench for vpu_dst_port: expected SRAM writes are queued when
// a command is issued and popped by a monitor as the DUT writes them.
module tb_vpu_dst_port;

    localparam int DW = 256;
    localparam int EW = 128;
    localparam int AW = 10;
    localparam int LW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          wvalid = 1'b0;
    logic [AW-1:0] waddr = '0;
    logic [LW-1:0] len = '0;
    logic          rvalid = 1'b0;
    logic [EW-1:0] rdata = '0;
    logic          rready;
    logic          wren;
    logic [AW-1:0] sw_addr;
    logic [DW-1:0] sw_data;
    logic          wready = 1'b1;
    logic          busy;
    logic          done;

    int total = 0;
    int bad = 0;
    int nwrites = 0;
    int ndone = 0;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;
    wr_t exp_q[$];

    always #5 clk = ~clk;

    vpu_dst_port dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start),
        .wvalid_i       (wvalid),
        .waddr_i        (waddr),
        .len_i          (len),
        .result_valid_i (rvalid),
        .result_data_i  (rdata),
        .result_ready_o (rready),
        .sram_wren_o    (wren),
        .sram_waddr_o   (sw_addr),
        .sram_wdata_o   (sw_data),
        .sram_wready_i  (wready),
        .busy_o         (busy),
        .done_o         (done)
    );

    // Scoreboard monitor: every accepted write must match the queue head.
    always @(negedge clk) begin
        if (rst_n && done) ndone++;
        if (rst_n && wren && wready) begin
            nwrites++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL sb_unexpected_write: addr=%h, no write expected", sw_addr);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                if (sw_addr !== e.addr || sw_data !== e.data) begin
                    bad++;
                    $display("FAIL sb_write: got addr=%h data=%h, want addr=%h data=%h",
                             sw_addr, sw_data, e.addr, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic wv, input logic [AW-1:0] a, input logic [LW-1:0] n);
        start = 1'b1; wvalid = wv; waddr = a; len = n;
        tick();
        start = 1'b0; wvalid = 1'b0;
    endtask

    task automatic expect_write(input logic [AW-1:0] a, input logic [EW-1:0] b0, input logic [EW-1:0] b1);
        wr_t e;
        e.addr = a;
        e.data = {b1, b0};
        exp_q.push_back(e);
    endtask

    task automatic send_beat(input logic [EW-1:0] d);
        rvalid = 1'b1; rdata = d;
        for (int i = 0; i < 50 && !rready; i++) tick();
        total++;
        if (!rready) begin
            bad++;
            $display("FAIL send_beat_timeout: ready=%b, want 1", rready);
        end
        tick();
        rvalid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        total++;
        if (!seen) begin
            bad++;
            $display("FAIL %s_done_timeout: done=%b, want 1", name, done);
        end
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, rready, wren} !== 4'b0 || sw_addr !== '0 || sw_data !== '0) begin
            bad++;
            $display("FAIL reset_outputs: busy=%b done=%b ready=%b wren=%b addr=%h, want all 0",
                     busy, done, rready, wren, sw_addr);
        end
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_word();
        int w0 = nwrites;
        int d0 = ndone;
        expect_write(10'h010, {32{4'hA}}, {32{4'h5}});
        wready = 1'b1;
        issue(1'b1, 10'h010, 4'd1);
        rvalid = 1'b1; rdata = {32{4'hA}};
        tick();
        rdata = {32{4'h5}};
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (wren !== 1'b1) begin
            bad++;
            $display("FAIL single_wren_latency: wren=%b, want 1", wren);
        end
        tick();
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL single_done_latency: done=%b, want 1", done);
        end
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL single_done_width: done=%b busy=%b, want 0 0", done, busy);
        end
        total++;
        if (nwrites - w0 != 1 || ndone - d0 != 1) begin
            bad++;
            $display("FAIL single_counts: writes=%0d dones=%0d, want 1 1", nwrites - w0, ndone - d0);
        end
    endtask

    task automatic test_no_dest();
        int w0 = nwrites;
        issue(1'b0, 10'h055, 4'd3);
        @(negedge clk);
        total++;
        if (done !== 1'b1 || rready !== 1'b0 || wren !== 1'b0) begin
            bad++;
            $display("FAIL nodest_done: done=%b ready=%b wren=%b, want 1 0 0", done, rready, wren);
        end
        tick();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (nwrites != w0 || busy !== 1'b0 || rready !== 1'b0) begin
            bad++;
            $display("FAIL nodest_idle: writes=%0d busy=%b ready=%b, want 0 0 0", nwrites - w0, busy, rready);
        end
    endtask

    task automatic test_backpressure();
        int w0 = nwrites;
        bit stable = 1;
        logic [DW-1:0] wd;
        wd = {{32{4'h2}}, {32{4'h1}}};
        expect_write(10'h100, {32{4'h1}}, {32{4'h2}});
        expect_write(10'h101, {32{4'h3}}, {32{4'h4}});
        wready = 1'b0;
        issue(1'b1, 10'h100, 4'd2);
        send_beat({32{4'h1}});
        send_beat({32{4'h2}});
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wren !== 1'b1 || sw_addr !== 10'h100 || sw_data !== wd || rready !== 1'b0) stable = 0;
            tick();
        end
        total++;
        if (!stable) begin
            bad++;
            $display("FAIL bp_stable: wren=%b addr=%h ready=%b, want 1 100 0 held", wren, sw_addr, rready);
        end
        wready = 1'b1;
        tick();
        send_beat({32{4'h3}});
        send_beat({32{4'h4}});
        wait_done("bp");
        total++;
        if (nwrites - w0 != 2) begin
            bad++;
            $display("FAIL bp_write_count: writes=%0d, want 2", nwrites - w0);
        end
    endtask

    task automatic test_bubbles();
        bit early = 0;
        expect_write(10'h020, {32{4'h6}}, {32{4'h9}});
        wready = 1'b1;
        issue(1'b1, 10'h020, 4'd1);
        rvalid = 1'b1; rdata = {32{4'h6}};
        tick();
        rvalid = 1'b0; rdata = {32{4'hF}};
        @(negedge clk); if (wren) early = 1;
        tick();
        @(negedge clk); if (wren) early = 1;
        tick();
        rvalid = 1'b1; rdata = {32{4'h9}};
        @(negedge clk); if (wren) early = 1;
        tick();
        rvalid = 1'b0;
        @(negedge clk);
        total++;
        if (early || wren !== 1'b1) begin
            bad++;
            $display("FAIL bubble_write_timing: early=%0d wren=%b, want early=0 wren=1", early, wren);
        end
        wait_done("bubble");
    endtask

    task automatic test_wrap();
        expect_write(10'h3FF, {4{32'h11112222}}, {4{32'h33334444}});
        expect_write(10'h000, {4{32'h55556666}}, {4{32'h77778888}});
        wready = 1'b1;
        issue(1'b1, 10'h3FF, 4'd2);
        send_beat({4{32'h11112222}});
        send_beat({4{32'h33334444}});
        send_beat({4{32'h55556666}});
        send_beat({4{32'h77778888}});
        wait_done("wrap");
    endtask

    task automatic test_reset_midop();
        int d0;
        issue(1'b1, 10'h040, 4'd1);
        send_beat({32{4'hD}});
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy, done, rready, wren} !== 4'b0 || sw_addr !== '0 || sw_data !== '0) begin
            bad++;
            $display("FAIL midop_reset_outputs: busy=%b done=%b ready=%b wren=%b, want all 0",
                     busy, done, rready, wren);
        end
        tick(); tick();
        rst_n = 1'b1;
        d0 = ndone;
        for (int i = 0; i < 4; i++) tick();
        total++;
        if (ndone != d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midop_no_done: dones=%0d busy=%b, want 0 0", ndone - d0, busy);
        end
        expect_write(10'h041, {32{4'h7}}, {32{4'h8}});
        issue(1'b1, 10'h041, 4'd1);
        send_beat({32{4'h7}});
        send_beat({32{4'h8}});
        wait_done("midop_fresh");
    endtask

    task automatic test_back_to_back();
        int d0 = ndone;
        issue(1'b0, 10'h000, 4'd0);
        @(negedge clk);
        total++;
        if (done !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first_done: done=%b, want 1", done);
        end
        tick();
        expect_write(10'h2A5, {32{4'hC}}, {32{4'h3}});
        issue(1'b1, 10'h2A5, 4'd1);
        total++;
        if (rready !== 1'b1) begin
            bad++;
            $display("FAIL b2b_start_honoured: ready=%b, want 1", rready);
        end
        send_beat({32{4'hC}});
        send_beat({32{4'h3}});
        wait_done("b2b");
        total++;
        if (ndone - d0 != 2) begin
            bad++;
            $display("FAIL b2b_done_count: dones=%0d, want 2", ndone - d0);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_no_dest();
        test_backpressure();
        test_bubbles();
        test_wrap();
        test_reset_midop();
        test_back_to_back();
        for (int i = 0; i < 3; i++) tick();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_leftover: pending=%0d, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vpu_dst_port.md
Name: vpu_dst_port

Overview:
- Result-side counterpart of the VPU source-operand port.
- Accepts EXEC_UNIT_DATA_WIDTH result beats from the VLANE and packs BEATS of them into one SRAM_DATA_WIDTH word.
- Writes each packed word to the destination SRAM write port at consecutive addresses, then reports completion to the VPU controller.
- Sits between the VLANE result output and the SRAM write interface, alongside the source port.

Parameters:
- SRAM_DATA_WIDTH, 256, SRAM word width.
- EXEC_UNIT_DATA_WIDTH, 128, result beat width; SRAM_DATA_WIDTH must be an integer multiple of it.
- BEATS, SRAM_DATA_WIDTH/EXEC_UNIT_DATA_WIDTH, beats per SRAM word (derived, not overridden).
- ADDR_W, 10, SRAM word address width.
- LEN_W, 4, width of the word-count field.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle start pulse from the controller.
- wvalid_i  in  1  instruction has a destination; sampled with start_i.
- waddr_i  in  ADDR_W  first destination word address; sampled with start_i.
- len_i  in  LEN_W  number of SRAM words to write; sampled with start_i.
- result_valid_i  in  1  VLANE result beat valid.
- result_data_i  in  EXEC_UNIT_DATA_WIDTH  result beat.
- result_ready_o  out  1  beat accepted when valid & ready.
- sram_wren_o  out  1  SRAM write request.
- sram_waddr_o  out  ADDR_W  SRAM write address.
- sram_wdata_o  out  SRAM_DATA_WIDTH  SRAM write data.
- sram_wready_i  in  1  write accepted when wren & wready.
- busy_o  out  1  high in any state other than IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n low): state=IDLE; beat counter, word counter, address and pack buffer cleared. All outputs are 0.
- Reset asserted mid-operation: abort immediately. No partial write is issued and no done pulse follows.
- States:
  - IDLE: on start_i, latch waddr_i and len_i. If wvalid_i=0 or len_i=0, go to DONE; otherwise go to COLLECT. start_i in any other state is ignored.
  - COLLECT: result_ready_o=1. Each accepted beat k (beat counter 0..BEATS-1) is stored at pack[k*EXEC_UNIT_DATA_WIDTH +: EXEC_UNIT_DATA_WIDTH], so beat 0 is the LSBs. When the beat with counter BEATS-1 is accepted, clear the beat counter and go to WRITE. No accept occurs while result_valid_i=0.
  - WRITE: result_ready_o=0, sram_wren_o=1, sram_waddr_o=current address, sram_wdata_o=pack. All three are held stable until sram_wready_i. On acceptance, address+1 (wraps modulo 2^ADDR_W) and word counter+1. If word counter+1 == len, go to DONE; otherwise go to COLLECT.
  - DONE: done_o=1 for exactly one cycle, then return to IDLE.
- Latency:
  - Last beat accepted in cycle t → sram_wren_o high in t+1.
  - Write accepted in cycle w → next word's COLLECT begins in w+1, or done_o high in w+1.
- Start-to-done with no write: start in cycle s, done_o in s+1.
- Back-to-back: start_i is honoured in the first cycle of IDLE after DONE.
- busy_o=1 in COLLECT, WRITE and DONE.
- All outputs are registered or decoded from registered state; no combinational path from result_valid_i to sram_wren_o.

Decomposition:
- VPU_PKG (shared package) gains:
  - DST_BEATS constant;
  - vpu_dst_state_t enum {IDLE, COLLECT, WRITE, DONE};
  - the write-request struct {wren, waddr, wdata}, shared with the SRAM write interface.
- Sub-module vpu_dst_port_packer holds the pack register and beat counter.
  - Inputs: clr, push, data.
  - Outputs: full_word, last_beat.
- The FSM, address counter and word counter stay in vpu_dst_port.

Test Plan:
- Single word: start(wvalid=1, waddr=0x010, len=1); beats 0xAAAA…, 0x5555… on consecutive cycles with wready=1 → one write, addr 0x010, data {0x5555…,0xAAAA…}; done_o 1 cycle after the write.
- No destination: start with wvalid=0, len=3 → no sram_wren_o; result_ready_o stays 0; done_o in the cycle after start.
- Backpressure: len=2, wready held 0 for 5 cycles on the first word → wren, waddr and wdata stable throughout, result_ready_o=0. Second word written to waddr+1; exactly 2 writes total.
- Valid bubbles: beats with result_valid_i toggling 1,0,0,1 → packing order preserved; write issued the cycle after the 2nd accepted beat.
- Address wrap: waddr=0x3FF, len=2 → writes at 0x3FF then 0x000.
- Reset mid-op: rst_n low after 1 beat of word 0 → all outputs 0 that same cycle. After release, a fresh start with len=1 writes only the new data (no stale beat), and no done pulse from the aborted run appears.
